// File: rtl/logic_unit_arbiter.sv
// Two-requester front end for the shared 16-bit logic unit: round-robin grant,
// IDLE/EXEC/RESP sequencing and a registered valid/ready response port.
module logic_unit_arbiter #(
   parameter int WIDTH = 16
) (
   input  logic             iClk,
   input  logic             iRst_n,
   input  logic             iReqValid0,
   input  logic             iReqValid1,
   input  logic [WIDTH-1:0] iReqA0,
   input  logic [WIDTH-1:0] iReqA1,
   input  logic [WIDTH-1:0] iReqB0,
   input  logic [WIDTH-1:0] iReqB1,
   input  logic [2:0]       iReqOp0,
   input  logic [2:0]       iReqOp1,
   output logic             oReqReady0,
   output logic             oReqReady1,
   output logic             oRespValid,
   input  logic             iRespReady,
   output logic [WIDTH-1:0] oRespData,
   output logic             oRespZero,
   output logic             oRespErr,
   output logic             oRespId,
   output logic             oBusy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state_q, state_d;
   logic             last_q, last_d;
   logic             gnt0, gnt1;
   logic [WIDTH-1:0] a_q, b_q;
   logic [2:0]       op_q;
   logic             id_q;
   logic [WIDTH-1:0] data_q;
   logic             zero_q, err_q, respid_q;
   logic [WIDTH-1:0] result;

   function automatic logic [WIDTH-1:0] lu_eval(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [2:0]       op);
      logic [WIDTH-1:0] r;
      case (op)
         3'd0:    r = ~a;
         3'd1:    r = ~b;
         3'd2:    r = a | b;
         3'd3:    r = a & b;
         3'd4:    r = a ^ b;
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic op_illegal(input logic [2:0] op);
      return (op > 3'd4);
   endfunction

   // On a tie the requester that was not granted last wins.
   assign gnt1   = iReqValid1 & (~iReqValid0 | ~last_q);
   assign gnt0   = iReqValid0 & ~gnt1;
   assign result = lu_eval(a_q, b_q, op_q);

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      oReqReady0 = 1'b0;
      oReqReady1 = 1'b0;
      case (state_q)
         IDLE: begin
            oReqReady0 = gnt0;
            oReqReady1 = gnt1;
            if (gnt0 | gnt1) begin
               state_d = EXEC;
               last_d  = gnt1;
            end
         end
         EXEC:    state_d = RESP;
         RESP:    if (iRespReady) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   always_ff @(posedge iClk) begin
      if (state_q == IDLE && (gnt0 | gnt1)) begin
         a_q  <= gnt1 ? iReqA1  : iReqA0;
         b_q  <= gnt1 ? iReqB1  : iReqB0;
         op_q <= gnt1 ? iReqOp1 : iReqOp0;
         id_q <= gnt1;
      end
   end

   // Response registers are cleared so the port reads as all-zero after reset.
   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         data_q   <= '0;
         zero_q   <= 1'b0;
         err_q    <= 1'b0;
         respid_q <= 1'b0;
      end else if (state_q == EXEC) begin
         data_q   <= result;
         zero_q   <= (result == '0);
         err_q    <= op_illegal(op_q);
         respid_q <= id_q;
      end
   end

   assign oRespValid = (state_q == RESP);
   assign oBusy      = (state_q != IDLE);
   assign oRespData  = data_q;
   assign oRespZero  = zero_q;
   assign oRespErr   = err_q;
   assign oRespId    = respid_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: directed requests push expected
// responses, a negedge monitor pops and compares on each response transfer.
module tb_logic_unit_arbiter;

   logic        clk = 1'b0;
   logic        iRst_n;
   logic        iReqValid0, iReqValid1;
   logic [15:0] iReqA0, iReqA1, iReqB0, iReqB1;
   logic [2:0]  iReqOp0, iReqOp1;
   logic        oReqReady0, oReqReady1;
   logic        oRespValid, iRespReady;
   logic [15:0] oRespData;
   logic        oRespZero, oRespErr, oRespId, oBusy;

   typedef struct packed {
      logic [15:0] d;
      logic        z;
      logic        e;
      logic        id;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   logic_unit_arbiter #(.WIDTH(16)) dut (
      .iClk(clk), .iRst_n(iRst_n),
      .iReqValid0(iReqValid0), .iReqValid1(iReqValid1),
      .iReqA0(iReqA0), .iReqA1(iReqA1),
      .iReqB0(iReqB0), .iReqB1(iReqB1),
      .iReqOp0(iReqOp0), .iReqOp1(iReqOp1),
      .oReqReady0(oReqReady0), .oReqReady1(oReqReady1),
      .oRespValid(oRespValid), .iRespReady(iRespReady),
      .oRespData(oRespData), .oRespZero(oRespZero),
      .oRespErr(oRespErr), .oRespId(oRespId), .oBusy(oBusy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: one pop per response transfer.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (iRst_n && oRespValid && iRespReady) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("resp_data", {16'h0, oRespData}, {16'h0, e.d});
               chk("resp_zero", {31'h0, oRespZero}, {31'h0, e.z});
               chk("resp_err",  {31'h0, oRespErr},  {31'h0, e.e});
               chk("resp_id",   {31'h0, oRespId},   {31'h0, e.id});
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after edge N+2 (RESP).
   task automatic issue(input bit who, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] op, input logic [15:0] ed,
                        input bit ez, input bit ee);
      bit got = 0;
      exp_t e;
      if (who) begin iReqValid1 = 1; iReqA1 = a; iReqB1 = b; iReqOp1 = op; end
      else     begin iReqValid0 = 1; iReqA0 = a; iReqB0 = b; iReqOp0 = op; end
      for (int k = 0; k < 20; k++) begin
         #1;
         if (who ? oReqReady1 : oReqReady0) begin got = 1; break; end
         @(posedge clk); #1;
      end
      if (!got) begin
         chk("grant_timeout", 32'd0, 32'd1);
         iReqValid0 = 0; iReqValid1 = 0;
         return;
      end
      e.d = ed; e.z = ez; e.e = ee; e.id = who;
      exp_q.push_back(e);
      @(posedge clk); #1;
      iReqValid0 = 0; iReqValid1 = 0;
      chk("exec_busy",  {31'h0, oBusy},      32'd1);
      chk("exec_valid", {31'h0, oRespValid}, 32'd0);
      @(posedge clk); #1;
      chk("resp_latency_valid", {31'h0, oRespValid}, 32'd1);
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 40; k++) begin
         if (!oBusy) return;
         @(posedge clk); #1;
      end
      chk("idle_timeout", {31'h0, oBusy}, 32'd0);
   endtask

   initial begin
      int k;
      iRst_n = 0; iRespReady = 1;
      iReqValid0 = 0; iReqValid1 = 0;
      iReqA0 = 0; iReqA1 = 0; iReqB0 = 0; iReqB1 = 0; iReqOp0 = 0; iReqOp1 = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid",  {31'h0, oRespValid}, 32'd0);
      chk("rst_busy",   {31'h0, oBusy},      32'd0);
      chk("rst_data",   {16'h0, oRespData},  32'd0);
      chk("rst_zero",   {31'h0, oRespZero},  32'd0);
      chk("rst_err",    {31'h0, oRespErr},   32'd0);
      chk("rst_id",     {31'h0, oRespId},    32'd0);
      chk("rst_rdy0",   {31'h0, oReqReady0}, 32'd0);
      chk("rst_rdy1",   {31'h0, oReqReady1}, 32'd0);
      iRst_n = 1;
      @(posedge clk); #1;
      chk("idle_rdy0_novalid", {31'h0, oReqReady0}, 32'd0);
      iReqValid0 = 1;
      #1;
      chk("idle_rdy0_same_cycle", {31'h0, oReqReady0}, 32'd1);
      chk("idle_rdy1_off",        {31'h0, oReqReady1}, 32'd0);

      // One op per legal opcode on requester 0.
      issue(0, 16'hF0F0, 16'h0FF0, 3'd0, 16'h0F0F, 0, 0); @(posedge clk); #1; wait_idle();
      issue(0, 16'hF0F0, 16'h0FF0, 3'd1, 16'hF00F, 0, 0); @(posedge clk); #1; wait_idle();
      issue(0, 16'hF0F0, 16'h0FF0, 3'd2, 16'hFFF0, 0, 0); @(posedge clk); #1; wait_idle();
      issue(0, 16'hF0F0, 16'h0FF0, 3'd3, 16'h00F0, 0, 0); @(posedge clk); #1; wait_idle();
      issue(0, 16'hF0F0, 16'h0FF0, 3'd4, 16'hFF00, 0, 0); @(posedge clk); #1; wait_idle();
      chk("idle_after_resp", {31'h0, oBusy}, 32'd0);

      // Zero result and illegal opcodes.
      issue(0, 16'h1234, 16'h1234, 3'd4, 16'h0000, 1, 0); @(posedge clk); #1; wait_idle();
      issue(1, 16'h1234, 16'h1234, 3'd6, 16'h0000, 1, 1); @(posedge clk); #1; wait_idle();
      issue(0, 16'hFFFF, 16'hFFFF, 3'd7, 16'h0000, 1, 1); @(posedge clk); #1; wait_idle();

      // Back-pressure: stall in RESP with a competing request pending.
      iRespReady = 0;
      issue(0, 16'hAAAA, 16'h5555, 3'd2, 16'hFFFF, 0, 0);
      iReqValid1 = 1; iReqA1 = 16'h0001; iReqB1 = 16'h0002; iReqOp1 = 3'd2;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_valid", {31'h0, oRespValid}, 32'd1);
         chk("bp_data",  {16'h0, oRespData},  32'h0000FFFF);
         chk("bp_rdy",   {30'h0, oReqReady1, oReqReady0}, 32'd0);
      end
      iRespReady = 1;
      @(posedge clk); #1;
      chk("bp_release_idle", {31'h0, oBusy},      32'd0);
      chk("bp_release_rdy1", {31'h0, oReqReady1}, 32'd1);
      iReqValid1 = 0;
      @(posedge clk); #1;

      // Reset during EXEC drops the op (last grant was requester 0 here).
      iReqValid0 = 1; iReqA0 = 16'h00FF; iReqB0 = 16'h0000; iReqOp0 = 3'd0;
      #1;
      chk("rstexec_rdy0", {31'h0, oReqReady0}, 32'd1);
      @(posedge clk); #1;
      iReqValid0 = 0;
      chk("rstexec_busy", {31'h0, oBusy}, 32'd1);
      iRst_n = 0;
      @(posedge clk); #1;
      chk("rstexec_valid", {31'h0, oRespValid}, 32'd0);
      chk("rstexec_busy0", {31'h0, oBusy},      32'd0);
      iRst_n = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("rstexec_noresp", {31'h0, oRespValid}, 32'd0);

      // Round-robin tie; first grant must be requester 0 since reset restored last-grant=1.
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back('{d: 16'h0FFF, z: 1'b0, e: 1'b0, id: 1'b0});
         exp_q.push_back('{d: 16'h000F, z: 1'b0, e: 1'b0, id: 1'b1});
      end
      iReqA0 = 16'h00FF; iReqB0 = 16'h0F0F; iReqOp0 = 3'd2;
      iReqA1 = 16'h00FF; iReqB1 = 16'h0F0F; iReqOp1 = 3'd3;
      iReqValid0 = 1; iReqValid1 = 1;
      k = 0;
      for (int c = 0; c < 60 && k < 4; c++) begin
         @(negedge clk);
         chk("rr_mutex", {31'h0, oReqReady0 & oReqReady1}, 32'd0);
         if (oReqReady0 | oReqReady1) begin
            chk("rr_order", {31'h0, oReqReady1}, k % 2);
            k++;
         end
      end
      @(posedge clk); #1;
      iReqValid0 = 0; iReqValid1 = 0;
      chk("rr_count", k, 32'd4);
      wait_idle();
      repeat (3) @(posedge clk);
      #1;
      chk("queue_empty", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
